// File: rtl/regfile_sb.sv
// Register file with a per-register pending scoreboard: issue reserves a destination,
// writeback fills it and releases the reservation, reads report readiness with a same-cycle bypass.
module regfile_sb #(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          issue_en,
  input  logic [AW-1:0] issue_rd,
  output logic          issue_stall,
  input  logic          wb_en,
  input  logic [AW-1:0] wb_rd,
  input  logic [DW-1:0] wb_data,
  input  logic [AW-1:0] ra_addr,
  input  logic [AW-1:0] rb_addr,
  output logic [DW-1:0] ra_data,
  output logic [DW-1:0] rb_data,
  output logic          ra_ready,
  output logic          rb_ready,
  output logic [AW:0]   pend_cnt,
  output logic          wb_err
);

  localparam int unsigned NR = 2 ** AW;
  localparam logic [AW:0] CntMax = (AW + 1)'(NR - 1);

  logic [DW-1:0] regs_q [NR];
  logic [NR-1:0] pending_q, pending_d;
  logic [NR-1:0] we, set_vec;
  logic [AW:0]   pend_cnt_q, pend_cnt_d;
  logic          wb_err_q, wb_err_d;

  logic wb_valid, wb_was_pend, issue_acc;
  logic ra_byp, rb_byp;

  assign wb_valid    = wb_en && (wb_rd != '0);
  assign wb_was_pend = pending_q[wb_rd];

  // A writeback to the same register in this cycle releases it, so the reservation may proceed.
  assign issue_stall = issue_en && pending_q[issue_rd] && !(wb_en && (wb_rd == issue_rd));
  assign issue_acc   = issue_en && !issue_stall && (issue_rd != '0);

  always_comb begin
    we = '0;
    if (wb_valid) we[wb_rd] = 1'b1;
  end

  always_comb begin
    set_vec = '0;
    if (issue_acc) set_vec[issue_rd] = 1'b1;
  end

  // Set is applied after clear so a same-register issue keeps the register pending.
  assign pending_d = (pending_q & ~we) | set_vec;

  always_comb begin
    pend_cnt_d = pend_cnt_q;
    if (issue_acc && !(wb_valid && wb_was_pend)) begin
      if (pend_cnt_q != CntMax) pend_cnt_d = pend_cnt_q + 1'b1;
    end else if (!issue_acc && wb_valid && wb_was_pend) begin
      if (pend_cnt_q != '0) pend_cnt_d = pend_cnt_q - 1'b1;
    end
  end

  assign wb_err_d = wb_err_q || (wb_valid && !wb_was_pend);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NR; i++) regs_q[i] <= '0;
      pending_q  <= '0;
      pend_cnt_q <= '0;
      wb_err_q   <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < NR; i++) begin
        if (we[i]) regs_q[i] <= wb_data;
      end
      pending_q  <= pending_d;
      pend_cnt_q <= pend_cnt_d;
      wb_err_q   <= wb_err_d;
    end
  end

  assign ra_byp = wb_valid && (wb_rd == ra_addr);
  assign rb_byp = wb_valid && (wb_rd == rb_addr);

  always_comb begin
    ra_data = '0;
    if (ra_byp) ra_data = wb_data;
    else if (ra_addr != '0) ra_data = regs_q[ra_addr];
  end

  always_comb begin
    rb_data = '0;
    if (rb_byp) rb_data = wb_data;
    else if (rb_addr != '0) rb_data = regs_q[rb_addr];
  end

  assign ra_ready = !pending_q[ra_addr] || ra_byp;
  assign rb_ready = !pending_q[rb_addr] || rb_byp;
  assign pend_cnt = pend_cnt_q;
  assign wb_err   = wb_err_q;

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: scoreboard reservation, bypass, error flag, reset behaviour.
module tb_regfile_sb;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          issue_en;
  logic [AW-1:0] issue_rd;
  logic          issue_stall;
  logic          wb_en;
  logic [AW-1:0] wb_rd;
  logic [DW-1:0] wb_data;
  logic [AW-1:0] ra_addr, rb_addr;
  logic [DW-1:0] ra_data, rb_data;
  logic          ra_ready, rb_ready;
  logic [AW:0]   pend_cnt;
  logic          wb_err;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  regfile_sb #(.DW(DW), .AW(AW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .issue_en   (issue_en),
    .issue_rd   (issue_rd),
    .issue_stall(issue_stall),
    .wb_en      (wb_en),
    .wb_rd      (wb_rd),
    .wb_data    (wb_data),
    .ra_addr    (ra_addr),
    .rb_addr    (rb_addr),
    .ra_data    (ra_data),
    .rb_data    (rb_data),
    .ra_ready   (ra_ready),
    .rb_ready   (rb_ready),
    .pend_cnt   (pend_cnt),
    .wb_err     (wb_err)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change and outputs are sampled 1ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    issue_en = 1'b0;
    issue_rd = '0;
    wb_en    = 1'b0;
    wb_rd    = '0;
    wb_data  = '0;
  endtask

  task automatic issue(input logic [AW-1:0] rd);
    issue_en = 1'b1;
    issue_rd = rd;
  endtask

  task automatic wb(input logic [AW-1:0] rd, input logic [DW-1:0] d);
    wb_en   = 1'b1;
    wb_rd   = rd;
    wb_data = d;
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    ra_addr = '0;
    rb_addr = '0;
    step();
    step();
    rst_n = 1'b1;

    // Post-reset state
    ra_addr = 5'd5; rb_addr = 5'd9;
    issue(5'd3);
    #1;
    check_eq("rst_pend_cnt", 64'(pend_cnt), 64'd0);
    check_eq("rst_wb_err", 64'(wb_err), 64'd0);
    check_eq("rst_ra_ready", 64'(ra_ready), 64'd1);
    check_eq("rst_rb_ready", 64'(rb_ready), 64'd1);
    check_eq("rst_ra_data", 64'(ra_data), 64'd0);
    check_eq("rst_stall", 64'(issue_stall), 64'd0);
    idle();

    // Issue, pending read, bypassed writeback, release
    issue(5'd5);
    step();
    idle();
    ra_addr = 5'd5;
    #1;
    check_eq("p1_ra_ready", 64'(ra_ready), 64'd0);
    check_eq("p1_pend_cnt", 64'(pend_cnt), 64'd1);
    wb(5'd5, 32'hDEADBEEF);
    #1;
    check_eq("byp_ra_data", 64'(ra_data), 64'hDEADBEEF);
    check_eq("byp_ra_ready", 64'(ra_ready), 64'd1);
    step();
    idle();
    #1;
    check_eq("rel_pend_cnt", 64'(pend_cnt), 64'd0);
    check_eq("store_ra_data", 64'(ra_data), 64'hDEADBEEF);
    check_eq("rel_ra_ready", 64'(ra_ready), 64'd1);

    // WAW stall, and same-cycle writeback lets the reservation through
    issue(5'd5);
    step();
    #1;
    check_eq("waw_stall", 64'(issue_stall), 64'd1);
    step();
    check_eq("waw_cnt", 64'(pend_cnt), 64'd1);
    wb(5'd5, 32'h55);
    #1;
    check_eq("waw_wb_nostall", 64'(issue_stall), 64'd0);
    step();
    idle();
    #1;
    check_eq("waw_cnt_same", 64'(pend_cnt), 64'd1);
    check_eq("waw_still_pend", 64'(ra_ready), 64'd0);
    check_eq("waw_data_written", 64'(ra_data), 64'h55);
    check_eq("waw_no_err", 64'(wb_err), 64'd0);
    wb(5'd5, 32'h66);
    step();
    idle();
    check_eq("waw_release", 64'(pend_cnt), 64'd0);

    // Register 0 is inert
    ra_addr = '0; rb_addr = '0;
    wb('0, 32'hFFFFFFFF);
    issue('0);
    #1;
    check_eq("r0_no_byp", 64'(ra_data), 64'd0);
    check_eq("r0_issue_nostall", 64'(issue_stall), 64'd0);
    step();
    idle();
    #1;
    check_eq("r0_ra_data", 64'(ra_data), 64'd0);
    check_eq("r0_rb_data", 64'(rb_data), 64'd0);
    check_eq("r0_ra_ready", 64'(ra_ready), 64'd1);
    check_eq("r0_rb_ready", 64'(rb_ready), 64'd1);
    check_eq("r0_wb_err", 64'(wb_err), 64'd0);
    check_eq("r0_pend_cnt", 64'(pend_cnt), 64'd0);

    // Port B readiness and bypass
    issue(5'd7);
    step();
    idle();
    rb_addr = 5'd7;
    #1;
    check_eq("rb_not_ready", 64'(rb_ready), 64'd0);
    wb(5'd7, 32'h77);
    #1;
    check_eq("rb_byp_data", 64'(rb_data), 64'h77);
    check_eq("rb_byp_ready", 64'(rb_ready), 64'd1);
    step();
    idle();
    check_eq("rb_cnt", 64'(pend_cnt), 64'd0);

    // Different-register issue and writeback in one cycle nets to zero
    issue(5'd10);
    step();
    issue(5'd11);
    step();
    check_eq("multi_cnt2", 64'(pend_cnt), 64'd2);
    idle();
    issue(5'd12);
    wb(5'd10, 32'hA);
    step();
    idle();
    check_eq("multi_cnt_net0", 64'(pend_cnt), 64'd2);
    wb(5'd11, 32'hB);
    step();
    wb(5'd12, 32'hC);
    step();
    idle();
    check_eq("multi_cnt0", 64'(pend_cnt), 64'd0);
    check_eq("multi_err0", 64'(wb_err), 64'd0);

    // Writeback to a non-pending register
    wb(5'd9, 32'h1234);
    step();
    idle();
    ra_addr = 5'd9;
    #1;
    check_eq("err_set", 64'(wb_err), 64'd1);
    check_eq("err_data", 64'(ra_data), 64'h1234);
    check_eq("err_cnt", 64'(pend_cnt), 64'd0);
    step();
    step();
    check_eq("err_sticky", 64'(wb_err), 64'd1);

    // Fill the scoreboard
    for (int r = 1; r < 32; r++) begin
      issue(AW'(r));
      step();
    end
    idle();
    #1;
    check_eq("fill_cnt", 64'(pend_cnt), 64'd31);
    issue(5'd31);
    #1;
    check_eq("fill_stall", 64'(issue_stall), 64'd1);

    // Reset overrides same-cycle traffic and drops reservations
    rst_n = 1'b0;
    wb(5'd9, 32'hAAAA);
    issue(5'd31);
    step();
    rst_n = 1'b1;
    idle();
    ra_addr = 5'd9; rb_addr = 5'd5;
    #1;
    check_eq("mid_rst_cnt", 64'(pend_cnt), 64'd0);
    check_eq("mid_rst_err", 64'(wb_err), 64'd0);
    check_eq("mid_rst_ra_data", 64'(ra_data), 64'd0);
    check_eq("mid_rst_rb_ready", 64'(rb_ready), 64'd1);
    issue(5'd31);
    #1;
    check_eq("mid_rst_stall", 64'(issue_stall), 64'd0);
    idle();
    wb(5'd5, 32'h1);
    step();
    idle();
    check_eq("post_rst_err", 64'(wb_err), 64'd1);
    check_eq("post_rst_cnt", 64'(pend_cnt), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 Parameter DW SHALL default to 32: register data width in bits.
REQ-002 Parameter AW SHALL default to 5: register address width; register count is 2**AW.
REQ-003 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  SHALL be a synchronous, active-low reset, sampled only on the rising edge of clk.
REQ-005 issue_en  input  1  SHALL request that issue_rd be reserved for a pending write.
REQ-006 issue_rd  input  AW  SHALL be the destination register to reserve.
REQ-007 issue_stall  output  1  SHALL be combinational; high means the current issue request is refused.
REQ-008 wb_en  input  1  SHALL be the writeback strobe.
REQ-009 wb_rd  input  AW  SHALL be the writeback destination register.
REQ-010 wb_data  input  DW  SHALL be the writeback data.
REQ-011 ra_addr, rb_addr  input  AW each  SHALL be the two read-port addresses.
REQ-012 ra_data, rb_data  output  DW each  SHALL be the combinational read data.
REQ-013 ra_ready, rb_ready  output  1 each  SHALL be combinational; high means the read data is valid (no write outstanding).
REQ-014 pend_cnt  output  AW+1  SHALL be the registered count of pending registers.
REQ-015 wb_err  output  1  SHALL be a registered, sticky flag: writeback arrived to a non-pending register.

Function
REQ-016 Write enable SHALL be a one-hot decode of wb_rd gated by wb_en; register wb_rd SHALL take wb_data at the clock edge.
REQ-017 Register 0 SHALL never be written, SHALL always read 0, and SHALL never become pending.
REQ-018 Read port x SHALL return wb_data when wb_en=1, wb_rd=x_addr and x_addr!=0 (same-cycle bypass); otherwise it SHALL return the stored value.
REQ-019 pending[i] SHALL be one bit per register; x_ready SHALL be !pending[x_addr] or a bypass hit per REQ-018.
REQ-020 issue_stall SHALL be issue_en and pending[issue_rd] and not (wb_en and wb_rd==issue_rd), which blocks write-after-write reservation.
REQ-021 An accepted issue (issue_en=1, issue_stall=0, issue_rd!=0) SHALL set pending[issue_rd] at the next edge.
REQ-022 A writeback with wb_rd!=0 SHALL clear pending[wb_rd] at the next edge.
REQ-023 When an accepted issue and a writeback target the same nonzero register in the same cycle, the set SHALL win: the data SHALL be written and the register SHALL stay pending.
REQ-024 pend_cnt SHALL move by +1, -1 or 0 per cycle to match the net pending change; same-register set and clear SHALL give a net 0.
REQ-025 pend_cnt SHALL never wrap; its maximum is 2**AW-1.
REQ-026 A writeback with wb_rd!=0 and pending[wb_rd]=0 SHALL still write the data and SHALL set wb_err; pend_cnt SHALL not decrement.
REQ-027 Issue or writeback to register 0 SHALL have no effect on state, SHALL not stall, and SHALL not set wb_err.
REQ-028 Read latency SHALL be 0 cycles, and write-to-read-from-storage latency SHALL be 1 cycle.

Reset
REQ-029 With rst_n=0 at an edge, all registers, pending bits, pend_cnt and wb_err SHALL clear to 0, overriding any same-cycle issue or writeback.
REQ-030 After reset, all ready outputs SHALL be 1, issue_stall SHALL be 0, and read data SHALL be 0.
REQ-031 A reset asserted mid-operation SHALL discard all outstanding reservations; a later writeback to a formerly pending register SHALL set wb_err.

Verification
REQ-032 Issue rd=5, then next cycle read ra_addr=5 -> ra_ready=0 and pend_cnt=1; then wb rd=5 data=0xDEADBEEF -> same cycle ra_data=0xDEADBEEF with ra_ready=1; next cycle pend_cnt=0.
REQ-033 Issue rd=5 while pending[5]=1 and no writeback -> issue_stall=1 and pend_cnt unchanged; repeat with wb rd=5 in the same cycle -> issue_stall=0 and pending[5] stays 1 with pend_cnt unchanged.
REQ-034 wb rd=0 data=0xFFFFFFFF, then read addr 0 on both ports -> data 0, ready 1, wb_err=0.
REQ-035 wb rd=9 with pending[9]=0 and data=0x1234 -> next cycle wb_err=1 and reg9=0x1234; wb_err stays 1 until reset.
REQ-036 Issue registers 1..31 on consecutive cycles -> pend_cnt=31; then reset -> all outputs return to their reset values on the next edge.
